// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the requesters (master) and the register-file write arbiter (slave).
interface regfile_write_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic                  enable;
    logic [3:0]            req;
    logic [4*ADDR_W-1:0]   req_addr;
    logic [4*DATA_W-1:0]   req_data;
    logic [3:0]            gnt;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  busy;

    modport master (
        output enable, req, req_addr, req_data,
        input  gnt, wr_en, wr_addr, wr_data, busy
    );

    modport slave (
        input  enable, req, req_addr, req_data,
        output gnt, wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among four requesters.
// Produces a registered one-cycle write; writes to register 0 are granted but suppressed.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic                    clk,
    input logic                    rst_n,
    regfile_write_arbiter_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e              state_q;
    logic [1:0]          ptr_q;
    logic [3:0]          gnt_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                busy_q;

    logic                found;
    logic [1:0]          win_idx;
    logic [1:0]          idx;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;

    // First requester at or after the pointer, wrapping modulo 4.
    always_comb begin
        found   = 1'b0;
        win_idx = ptr_q;
        idx     = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && bus.req[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    assign win_addr = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
    assign win_data = bus.req_data[win_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.enable && found) begin
                        state_q   <= StGrant;
                        ptr_q     <= win_idx + 2'd1;
                        gnt_q     <= 4'b0001 << win_idx;
                        wr_addr_q <= win_addr;
                        wr_data_q <= win_data;
                        wr_en_q   <= (win_addr != '0);
                        busy_q    <= 1'b1;
                    end
                end
                StGrant: begin
                    // Address/data hold their last values; only the strobes drop.
                    state_q <= StIdle;
                    gnt_q   <= 4'b0000;
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= 4'b0000;
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a behavioural round-robin model.
module tb_regfile_write_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic clk;
    logic rst_n;

    regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: pending grant lasts one cycle; winner is first set request
    // scanning from the pointer with modulo-4 arithmetic.
    int          m_ptr;
    logic        m_busy;
    logic [3:0]  m_gnt;
    logic        m_wr_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr   <= 0;
            m_busy  <= 1'b0;
            m_gnt   <= 4'b0000;
            m_wr_en <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
        end else if (m_busy) begin
            m_busy  <= 1'b0;
            m_gnt   <= 4'b0000;
            m_wr_en <= 1'b0;
        end else if (bus.enable && bus.req != 4'b0000) begin
            int  w;
            int  j;
            bit  hit;
            hit = 0;
            w   = 0;
            for (int k = 0; k < 4; k++) begin
                j = (m_ptr + k) % 4;
                if (!hit && bus.req[j]) begin
                    hit = 1;
                    w   = j;
                end
            end
            m_busy  <= 1'b1;
            m_gnt   <= 4'(1 << w);
            m_ptr   <= (w + 1) % 4;
            m_addr  <= bus.req_addr[w*5 +: 5];
            m_data  <= bus.req_data[w*32 +: 32];
            m_wr_en <= (bus.req_addr[w*5 +: 5] != 5'd0);
        end
    end

    logic [3:0] prev_gnt = 4'b0000;
    logic       prev_wen = 1'b0;

    always @(negedge clk) begin
        check_eq("model_gnt",   32'(bus.gnt),   32'(m_gnt));
        check_eq("model_wr_en", 32'(bus.wr_en), 32'(m_wr_en));
        check_eq("model_busy",  32'(bus.busy),  32'(m_busy));
        check_eq("model_waddr", 32'(bus.wr_addr), 32'(m_addr));
        check_eq("model_wdata", bus.wr_data, m_data);
        check_eq("gnt_b2b", 32'((prev_gnt != 0) && (bus.gnt != 0)), 32'd0);
        check_eq("wen_b2b", 32'(prev_wen && bus.wr_en), 32'd0);
        prev_gnt = bus.gnt;
        prev_wen = bus.wr_en;
    end

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        bus.req[i]            = 1'b1;
        bus.req_addr[i*5 +: 5] = a;
        bus.req_data[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int seen;
    int order_idx;

    initial begin
        rst_n        = 1'b0;
        bus.enable   = 1'b0;
        bus.req      = 4'b0000;
        bus.req_addr = '0;
        bus.req_data = '0;

        // Reset and idle
        repeat (3) @(negedge clk);
        check_eq("rst_gnt",   32'(bus.gnt), 32'd0);
        check_eq("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check_eq("rst_waddr", 32'(bus.wr_addr), 32'd0);
        check_eq("rst_wdata", bus.wr_data, 32'd0);
        check_eq("rst_busy",  32'(bus.busy), 32'd0);
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.gnt != 0) seen++;
        end
        check_eq("idle_no_gnt", 32'(seen), 32'd0);

        // Single request from requester 2
        set_req(2, 5'd9, 32'hDEADBEEF);
        @(negedge clk);
        check_eq("single_gnt",   32'(bus.gnt), 32'h4);
        check_eq("single_wr_en", 32'(bus.wr_en), 32'd1);
        check_eq("single_waddr", 32'(bus.wr_addr), 32'd9);
        check_eq("single_wdata", bus.wr_data, 32'hDEADBEEF);
        bus.req = 4'b0000;
        @(negedge clk);
        check_eq("single_clr_gnt",  32'(bus.gnt), 32'd0);
        check_eq("single_clr_wen",  32'(bus.wr_en), 32'd0);
        check_eq("single_hold_adr", 32'(bus.wr_addr), 32'd9);
        // Pointer is now 3: with 0 and 3 requesting, 3 wins
        set_req(0, 5'd1, 32'h0);
        set_req(3, 5'd4, 32'h3);
        @(negedge clk);
        check_eq("ptr3_gnt", 32'(bus.gnt), 32'h8);
        bus.req = 4'b0000;
        @(negedge clk);

        // Fairness and wrap from a fresh pointer
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'(32'hA0 + i));
        order_idx = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.gnt != 0) begin
                check_eq("rr_order", 32'(bus.gnt), 32'(1 << (order_idx % 4)));
                check_eq("rr_addr", 32'(bus.wr_addr), 32'((order_idx % 4) + 1));
                order_idx++;
            end
        end
        check_eq("rr_count", 32'(order_idx), 32'd8);
        bus.req = 4'b0000;
        @(negedge clk);

        // Register 0: granted but not written
        set_req(0, 5'd0, 32'h1234);
        @(negedge clk);
        check_eq("zero_gnt",   32'(bus.gnt), 32'h1);
        check_eq("zero_wr_en", 32'(bus.wr_en), 32'd0);
        bus.req = 4'b0000;
        @(negedge clk);
        set_req(0, 5'd3, 32'h5);
        set_req(1, 5'd7, 32'h6);
        @(negedge clk);
        check_eq("zero_ptr1", 32'(bus.gnt), 32'h2);
        bus.req = 4'b0000;
        @(negedge clk);

        // Enable gating
        bus.enable = 1'b0;
        set_req(1, 5'd12, 32'hCAFE0001);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.gnt != 0) seen++;
        end
        check_eq("en_off_no_gnt", 32'(seen), 32'd0);
        bus.enable = 1'b1;
        @(posedge clk);
        #1 bus.enable = 1'b0;
        @(negedge clk);
        check_eq("en_gnt",   32'(bus.gnt), 32'h2);
        check_eq("en_wr_en", 32'(bus.wr_en), 32'd1);
        check_eq("en_wdata", bus.wr_data, 32'hCAFE0001);
        repeat (3) @(negedge clk);
        check_eq("en_off_held", 32'(bus.gnt), 32'd0);
        bus.req    = 4'b0000;
        bus.enable = 1'b1;

        // Reset in the middle of a grant
        do_reset();
        set_req(2, 5'd17, 32'h77);
        @(negedge clk);
        check_eq("mid_gnt", 32'(bus.gnt), 32'h4);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_gnt",  32'(bus.gnt), 32'd0);
        check_eq("mid_rst_wen",  32'(bus.wr_en), 32'd0);
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst_addr", 32'(bus.wr_addr), 32'd0);
        @(negedge clk);
        bus.req = 4'b0000;
        set_req(0, 5'd2, 32'h10);
        set_req(2, 5'd6, 32'h12);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_after_gnt", 32'(bus.gnt), 32'h1);
        bus.req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_after_gnt2", 32'(bus.gnt), 32'h4);
        bus.req = 4'b0000;
        @(negedge clk);

        // Randomized traffic honouring the requester handshake
        repeat (600) begin
            @(negedge clk);
            bus.enable = ($urandom_range(0, 99) < 85);
            for (int i = 0; i < 4; i++) begin
                logic [4:0]  a;
                logic [31:0] d;
                a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                d = $urandom;
                if (m_gnt[i]) begin
                    if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
                    else set_req(i, a, d);
                end else if (!bus.req[i] && $urandom_range(0, 99) < 30) begin
                    set_req(i, a, d);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin arbiter that shares the single register-file write port among four requesters (e.g. WB stage, load return, MFHI/MFLO move, debug port). It samples requests, picks one fairly, and drives a registered one-cycle write (enable, address, data) into the register file's write decoder. It also returns a one-hot grant to the winning requester. Writes to register 0 are consumed but never performed.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (register 0 is hard-wired zero)
- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous, active-low reset
- ENABLE  input  1  1 = arbitration allowed; 0 = no new grants (an in-flight grant completes)
- REQ  input  4  per-requester write request, level, held until granted
- REQ_ADDR  input  4*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
- REQ_DATA  input  4*DATA_W  requester i data at [i*DATA_W +: DATA_W]
- GNT  output  4  one-hot grant, high for exactly one cycle
- WR_EN  output  1  register-file write enable
- WR_ADDR  output  ADDR_W  register-file write address
- WR_DATA  output  DATA_W  register-file write data
- BUSY  output  1  1 while in GRANT state

## Operation
- Two-state FSM: IDLE, GRANT. Reset state IDLE.
- IDLE: if ENABLE=1 and REQ!=0, select winner w, go to GRANT. Otherwise stay in IDLE.
- GRANT: unconditionally return to IDLE. REQ is ignored in GRANT.
- Winner selection: search indices PTR, PTR+1, PTR+2, PTR+3 (mod 4). The first with REQ set wins.
- PTR: 2-bit round-robin pointer, reset 0. On entering GRANT with winner w, PTR <= w+1 (mod 4; 3 wraps to 0).
- Entering GRANT registers these values:
  - GNT <= one-hot(w), decoded from the 2-bit index.
  - WR_ADDR <= REQ_ADDR[w].
  - WR_DATA <= REQ_DATA[w].
  - WR_EN <= (REQ_ADDR[w] != 0).
- Address 0 requests are granted (GNT pulses, PTR advances) but WR_EN stays 0.
- Leaving GRANT clears GNT and WR_EN to 0. WR_ADDR and WR_DATA hold their last values.
- BUSY = (state == GRANT).
- Requester handshake:
  - Hold REQ, REQ_ADDR and REQ_DATA stable until GNT[i] is seen high.
  - Then deassert REQ, or keep it high for a back-to-back write with new address/data by the end of the GRANT cycle.
- ENABLE=0 while in GRANT: the grant completes normally. No new grant is issued while ENABLE=0.
- Reset (async, any state): immediately clears state to IDLE, PTR=0, GNT=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, BUSY=0.
  - A grant cut short by reset does not write.
  - The requester must re-request after reset.

## Timing
- Reset values: GNT=4'b0000, WR_EN=0, WR_ADDR=0, WR_DATA=0, BUSY=0.
- Latency: REQ sampled high at edge k (state IDLE) gives GNT/WR_EN high during cycle k..k+1. The register file writes at edge k+1.
- Max throughput: one write per 2 cycles. With all REQ held high, grants follow PTR order 0,1,2,3,0,...
- GNT, WR_EN and BUSY are never high for two consecutive cycles.
- All outputs are registered. No combinational path from REQ to any output.

## Test plan
- Reset/idle: hold RESET_N=0, then release with REQ=0 -> all outputs 0, no GNT for 20 cycles.
- Single request: REQ=4'b0100, addr 5'd9, data 32'hDEADBEEF -> one cycle later GNT=4'b0100, WR_EN=1, WR_ADDR=9, WR_DATA=32'hDEADBEEF. Next cycle all clear and PTR=3.
- Fairness/wrap: REQ=4'b1111 held for 16 cycles -> grant order 0,1,2,3,0,1,2,3. GNT is high on alternate cycles only. PTR wraps 3->0.
- Zero register: REQ=4'b0001, addr 0, data 32'h1234 -> GNT=4'b0001 pulses, WR_EN stays 0, PTR becomes 1.
- ENABLE gating: ENABLE=0 with REQ=4'b0010 -> no grant. Raising ENABLE gives GNT=4'b0010 on the next cycle. Dropping ENABLE during GRANT still completes that write.
- Reset mid-grant: assert RESET_N=0 during the GRANT cycle of requester 2 -> GNT and WR_EN drop immediately, PTR=0. After release with REQ=4'b0101, requester 0 wins first.
